// File: rtl/cci_mpf_vtp_csr_ctrl.sv
// cci_mpf_vtp_csr_ctrl
// MMIO-side CSR engine for the MPF VTP shim. It decodes host MMIO reads and writes
// that fall in the VTP CSR window and holds these registers: DFH, ID, MODE,
// page-table root address and the TLB statistics counters. It drives the mode and
// page-table outputs into the translation pipeline and runs the translation-cache
// invalidate request/ack handshake.
//
// CSR k sits at word address DFH_MMIO_BASE_ADDR + 2k, for k = 0..7.
//
// Optional feature: define CCI_MPF_VTP_CSR_STATS_EN to build the hit/miss counters.
// When it is undefined, there are no counter flops and the counter CSRs read 0.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   mmio_wr_*           64-bit MMIO write: strobe, word address, data
//   mmio_rd_*           64-bit MMIO read: strobe, word address, transaction id
//   mmio_rsp_*          read response, two cycles after the request; tid is echoed
//   csr_mode            {inval_translation_cache, enabled}
//   inval_ack           translation pipeline has finished invalidating
//   pt_paddr(_valid)    page-table root address; valid once it has been written
//   tlb_hit, tlb_miss   single-cycle event pulses from the translation cache
module cci_mpf_vtp_csr_ctrl #(
   parameter int unsigned MMIO_ADDR_WIDTH    = 16,
   parameter int unsigned DFH_MMIO_BASE_ADDR = 0,
   parameter int unsigned DFH_MMIO_NEXT_ADDR = 0,
   parameter int unsigned COUNTER_WIDTH      = 48
) (
   input  logic                       clk,
   input  logic                       reset_n,

   input  logic                       mmio_wr_valid,
   input  logic [MMIO_ADDR_WIDTH-1:0] mmio_wr_addr,
   input  logic [63:0]                mmio_wr_data,

   input  logic                       mmio_rd_valid,
   input  logic [MMIO_ADDR_WIDTH-1:0] mmio_rd_addr,
   input  logic [8:0]                 mmio_rd_tid,

   output logic                       mmio_rsp_valid,
   output logic [8:0]                 mmio_rsp_tid,
   output logic [63:0]                mmio_rsp_data,

   output logic [1:0]                 csr_mode,
   input  logic                       inval_ack,

   output logic [63:0]                pt_paddr,
   output logic                       pt_paddr_valid,

   input  logic                       tlb_hit,
   input  logic                       tlb_miss
);

   localparam int unsigned AW = MMIO_ADDR_WIDTH;
   localparam int unsigned DW = 64;
   localparam int unsigned TW = 9;

   localparam logic          DFH_EOL     = (DFH_MMIO_NEXT_ADDR == 0);
   // The byte offset to the next DFH: four bytes per MMIO word.
   localparam logic [23:0]   NEXT_OFFSET = DFH_EOL ? 24'd0 :
                                24'((DFH_MMIO_NEXT_ADDR - DFH_MMIO_BASE_ADDR) * 4);
   localparam logic [DW-1:0] DFH_VALUE   = {4'h1, 19'h0, DFH_EOL, NEXT_OFFSET, 16'h0};
   // VTP feature UUID c8a2982f-ff96-42bf-a705-45727f501901
   localparam logic [DW-1:0] ID_L_VALUE  = 64'ha705_4572_7f50_1901;
   localparam logic [DW-1:0] ID_H_VALUE  = 64'hc8a2_982f_ff96_42bf;

   typedef enum logic [2:0] {
      CSR_DFH      = 3'd0,
      CSR_ID_L     = 3'd1,
      CSR_ID_H     = 3'd2,
      CSR_MODE     = 3'd3,
      CSR_PT_PADDR = 3'd4,
      CSR_HIT_CNT  = 3'd5,
      CSR_MISS_CNT = 3'd6,
      CSR_RSVD     = 3'd7
   } t_csr_idx;

   typedef struct packed {
      logic inval_translation_cache;
      logic enabled;
   } t_cci_mpf_vtp_csr_mode;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_INVAL = 1'b1
   } t_inval_state;

   // Address decode. An address below the base wraps to a large offset and misses.
   logic [AW-1:0] wr_off_c, rd_off_c;
   logic          wr_hit_c, rd_hit_c;
   t_csr_idx      wr_idx_c, rd_idx_c;
   logic          wr_mode_c, wr_pt_c;

   assign wr_off_c  = mmio_wr_addr - AW'(DFH_MMIO_BASE_ADDR);
   assign rd_off_c  = mmio_rd_addr - AW'(DFH_MMIO_BASE_ADDR);
   assign wr_hit_c  = mmio_wr_valid && (wr_off_c[AW-1:4] == '0) && !wr_off_c[0];
   assign rd_hit_c  = mmio_rd_valid && (rd_off_c[AW-1:4] == '0) && !rd_off_c[0];
   assign wr_idx_c  = t_csr_idx'(wr_off_c[3:1]);
   assign rd_idx_c  = t_csr_idx'(rd_off_c[3:1]);
   assign wr_mode_c = wr_hit_c && (wr_idx_c == CSR_MODE);
   assign wr_pt_c   = wr_hit_c && (wr_idx_c == CSR_PT_PADDR);

   // Invalidate handshake FSM
   t_inval_state state_q, state_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Extra invalidate requests that arrive while busy merge into the one in flight.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (wr_mode_c && mmio_wr_data[1]) state_d = ST_INVAL;
         ST_INVAL: if (inval_ack)                    state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Mode and page-table registers
   logic                  enabled_q;
   t_cci_mpf_vtp_csr_mode mode;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enabled_q      <= 1'b0;
         pt_paddr       <= '0;
         pt_paddr_valid <= 1'b0;
      end else begin
         if (wr_mode_c) enabled_q <= mmio_wr_data[0];
         if (wr_pt_c) begin
            pt_paddr       <= mmio_wr_data;
            pt_paddr_valid <= 1'b1;
         end
      end
   end

   assign mode.inval_translation_cache = (state_q == ST_INVAL);
   assign mode.enabled                 = enabled_q;
   assign csr_mode                     = mode;

   // TLB statistics
   logic [DW-1:0] hit_rd_c, miss_rd_c;

`ifdef CCI_MPF_VTP_CSR_STATS_EN
   logic [COUNTER_WIDTH-1:0] hit_cnt_q, miss_cnt_q;
   logic                     wr_hit_cnt_c, wr_miss_cnt_c;

   assign wr_hit_cnt_c  = wr_hit_c && (wr_idx_c == CSR_HIT_CNT);
   assign wr_miss_cnt_c = wr_hit_c && (wr_idx_c == CSR_MISS_CNT);

   // A clear has priority over an increment in the same cycle. The counters saturate at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (wr_hit_cnt_c)                 hit_cnt_q  <= '0;
         else if (tlb_hit && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + COUNTER_WIDTH'(1);
         if (wr_miss_cnt_c)                  miss_cnt_q <= '0;
         else if (tlb_miss && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + COUNTER_WIDTH'(1);
      end
   end

   assign hit_rd_c  = DW'(hit_cnt_q);
   assign miss_rd_c = DW'(miss_cnt_q);
`else
   logic unused_stats;

   assign unused_stats = ^{tlb_hit, tlb_miss, COUNTER_WIDTH[0]};
   assign hit_rd_c     = '0;
   assign miss_rd_c    = '0;
`endif

   // Read mux. A read samples register values from before any write in the same cycle.
   logic [DW-1:0] rd_data_c;

   always_comb begin
      rd_data_c = '0;
      case (rd_idx_c)
         CSR_DFH:      rd_data_c = DFH_VALUE;
         CSR_ID_L:     rd_data_c = ID_L_VALUE;
         CSR_ID_H:     rd_data_c = ID_H_VALUE;
         CSR_MODE:     rd_data_c = {62'h0, mode.inval_translation_cache, mode.enabled};
         CSR_PT_PADDR: rd_data_c = pt_paddr;
         CSR_HIT_CNT:  rd_data_c = hit_rd_c;
         CSR_MISS_CNT: rd_data_c = miss_rd_c;
         default:      rd_data_c = '0;
      endcase
   end

   // Two-stage read response pipeline. Reset drops any responses in flight.
   logic          rd_valid_q;
   logic [TW-1:0] rd_tid_q;
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q     <= 1'b0;
         rd_tid_q       <= '0;
         rd_data_q      <= '0;
         mmio_rsp_valid <= 1'b0;
         mmio_rsp_tid   <= '0;
         mmio_rsp_data  <= '0;
      end else begin
         rd_valid_q     <= rd_hit_c;
         if (rd_hit_c) begin
            rd_tid_q  <= mmio_rd_tid;
            rd_data_q <= rd_data_c;
         end
         mmio_rsp_valid <= rd_valid_q;
         if (rd_valid_q) begin
            mmio_rsp_tid  <= rd_tid_q;
            mmio_rsp_data <= rd_data_q;
         end
      end
   end

endmodule

// File: tb/tb_cci_mpf_vtp_csr_ctrl.sv
// Bench for cci_mpf_vtp_csr_ctrl: directed MMIO traffic with a response scoreboard.
module tb_cci_mpf_vtp_csr_ctrl;

   localparam logic [15:0] A_DFH  = 16'h0040;
   localparam logic [15:0] A_IDL  = 16'h0042;
   localparam logic [15:0] A_IDH  = 16'h0044;
   localparam logic [15:0] A_MODE = 16'h0046;
   localparam logic [15:0] A_PT   = 16'h0048;
   localparam logic [15:0] A_HIT  = 16'h004A;
   localparam logic [15:0] A_MISS = 16'h004C;
   localparam logic [15:0] A_RSVD = 16'h004E;

   localparam logic [63:0] DFH_EXP  = 64'h1000_0100_0000_0000;
   localparam logic [63:0] IDL_EXP  = 64'ha705_4572_7f50_1901;
   localparam logic [63:0] IDH_EXP  = 64'hc8a2_982f_ff96_42bf;

`ifdef CCI_MPF_VTP_CSR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        mmio_wr_valid;
   logic [15:0] mmio_wr_addr;
   logic [63:0] mmio_wr_data;
   logic        mmio_rd_valid;
   logic [15:0] mmio_rd_addr;
   logic [8:0]  mmio_rd_tid;
   logic        mmio_rsp_valid;
   logic [8:0]  mmio_rsp_tid;
   logic [63:0] mmio_rsp_data;
   logic [1:0]  csr_mode;
   logic        inval_ack;
   logic [63:0] pt_paddr;
   logic        pt_paddr_valid;
   logic        tlb_hit;
   logic        tlb_miss;

   cci_mpf_vtp_csr_ctrl #(
      .MMIO_ADDR_WIDTH    (16),
      .DFH_MMIO_BASE_ADDR (32'h40),
      .DFH_MMIO_NEXT_ADDR (0),
      .COUNTER_WIDTH      (4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .mmio_wr_valid  (mmio_wr_valid),
      .mmio_wr_addr   (mmio_wr_addr),
      .mmio_wr_data   (mmio_wr_data),
      .mmio_rd_valid  (mmio_rd_valid),
      .mmio_rd_addr   (mmio_rd_addr),
      .mmio_rd_tid    (mmio_rd_tid),
      .mmio_rsp_valid (mmio_rsp_valid),
      .mmio_rsp_tid   (mmio_rsp_tid),
      .mmio_rsp_data  (mmio_rsp_data),
      .csr_mode       (csr_mode),
      .inval_ack      (inval_ack),
      .pt_paddr       (pt_paddr),
      .pt_paddr_valid (pt_paddr_valid),
      .tlb_hit        (tlb_hit),
      .tlb_miss       (tlb_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [8:0]  tid;
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t sb_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (mmio_rsp_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: got tid %0d data 0x%0h, expected no response (cycle %0d)",
                     mmio_rsp_tid, mmio_rsp_data, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rsp_data", mmio_rsp_data, e.data);
            check("rsp_tid", 64'(mmio_rsp_tid), 64'(e.tid));
            check("rsp_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   // All drive tasks start and end just after a falling edge.
   task automatic rd(input logic [15:0] a, input logic [8:0] t, input bit exp_rsp,
                     input logic [63:0] d);
      mmio_rd_valid = 1'b1;
      mmio_rd_addr  = a;
      mmio_rd_tid   = t;
      if (exp_rsp) sb_q.push_back('{t, d, cyc + 2});
      @(negedge clk);
      mmio_rd_valid = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      mmio_wr_valid = 1'b1;
      mmio_wr_addr  = a;
      mmio_wr_data  = d;
      @(negedge clk);
      mmio_wr_valid = 1'b0;
   endtask

   task automatic pulse(input logic h, input logic m);
      tlb_hit  = h;
      tlb_miss = m;
      @(negedge clk);
      tlb_hit  = 1'b0;
      tlb_miss = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n       = 1'b0;
      mmio_wr_valid = 1'b0;
      mmio_wr_addr  = '0;
      mmio_wr_data  = '0;
      mmio_rd_valid = 1'b0;
      mmio_rd_addr  = '0;
      mmio_rd_tid   = '0;
      inval_ack     = 1'b0;
      tlb_hit       = 1'b0;
      tlb_miss      = 1'b0;
      idle(3);
      check("reset_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
      check("reset_csr_mode", 64'(csr_mode), 64'd0);
      check("reset_pt_paddr", pt_paddr, 64'd0);
      check("reset_pt_valid", 64'(pt_paddr_valid), 64'd0);
      reset_n = 1'b1;
      idle(2);

      // Identity and default registers, back-to-back reads
      rd(A_DFH,  9'd5,  1'b1, DFH_EXP);
      rd(A_IDL,  9'd6,  1'b1, IDL_EXP);
      rd(A_IDH,  9'd7,  1'b1, IDH_EXP);
      rd(A_MODE, 9'd8,  1'b1, 64'd0);
      rd(A_PT,   9'd9,  1'b1, 64'd0);
      rd(A_RSVD, 9'd10, 1'b1, 64'd0);
      idle(3);

      // Out of window or odd address: no response
      rd(A_DFH + 16'd16, 9'd11, 1'b0, 64'd0);
      rd(A_DFH + 16'd1,  9'd12, 1'b0, 64'd0);
      rd(A_DFH - 16'd2,  9'd13, 1'b0, 64'd0);
      idle(3);

      // Page-table address
      wr(A_PT, 64'h1234_5000);
      check("pt_paddr", pt_paddr, 64'h1234_5000);
      check("pt_valid", 64'(pt_paddr_valid), 64'd1);
      rd(A_PT, 9'd14, 1'b1, 64'h1234_5000);
      // Read and write in the same cycle: the read sees the old value
      mmio_wr_valid = 1'b1;
      mmio_wr_addr  = A_PT;
      mmio_wr_data  = 64'hABCD_E000;
      rd(A_PT, 9'd15, 1'b1, 64'h1234_5000);
      mmio_wr_valid = 1'b0;
      rd(A_PT, 9'd16, 1'b1, 64'hABCD_E000);
      wr(A_PT + 16'd1, 64'h0);
      wr(A_RSVD, 64'hFFFF_FFFF);
      rd(A_PT,   9'd17, 1'b1, 64'hABCD_E000);
      rd(A_RSVD, 9'd18, 1'b1, 64'd0);
      idle(3);

      // Invalidate handshake: write at c, inval high c+1..c+4, ack at c+4
      wr(A_MODE, 64'h3);
      check("inval_c1", 64'(csr_mode), 64'h3);
      rd(A_MODE, 9'd19, 1'b1, 64'h3);
      check("inval_c2", 64'(csr_mode[1]), 64'd1);
      wr(A_MODE, 64'h3);
      check("inval_c3", 64'(csr_mode[1]), 64'd1);
      idle(1);
      check("inval_c4", 64'(csr_mode[1]), 64'd1);
      inval_ack = 1'b1;
      idle(1);
      inval_ack = 1'b0;
      check("inval_c5", 64'(csr_mode), 64'h1);
      rd(A_MODE, 9'd20, 1'b1, 64'h1);
      idle(2);
      check("inval_no_requeue", 64'(csr_mode), 64'h1);
      inval_ack = 1'b1;
      idle(1);
      inval_ack = 1'b0;
      idle(1);
      check("ack_in_idle", 64'(csr_mode), 64'h1);
      wr(A_MODE + 16'd1, 64'h0);
      check("mode_odd_write", 64'(csr_mode), 64'h1);
      wr(A_MODE, 64'h0);
      check("mode_disable", 64'(csr_mode), 64'h0);

      // Statistics: 8 hit-only, 2 coincident, 1 miss-only -> 10 hits, 3 misses
      for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) pulse(1'b1, 1'b1);
      pulse(1'b0, 1'b1);
      rd(A_HIT,  9'd21, 1'b1, STATS ? 64'd10 : 64'd0);
      rd(A_MISS, 9'd22, 1'b1, STATS ? 64'd3  : 64'd0);
      // A clear and an increment in the same cycle give 0
      tlb_hit = 1'b1;
      wr(A_HIT, 64'h0);
      tlb_hit = 1'b0;
      rd(A_HIT,  9'd23, 1'b1, 64'd0);
      rd(A_MISS, 9'd24, 1'b1, STATS ? 64'd3 : 64'd0);
      for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0);
      rd(A_HIT, 9'd25, 1'b1, STATS ? 64'd15 : 64'd0);
      wr(A_MISS, 64'h0);
      rd(A_MISS, 9'd26, 1'b1, 64'd0);
      idle(3);

      // Reset while a read is in flight
      wr(A_MODE, 64'h1);
      rd(A_PT, 9'd27, 1'b0, 64'd0);
      reset_n = 1'b0;
      idle(1);
      check("rst_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
      check("rst_rsp_tid", 64'(mmio_rsp_tid), 64'd0);
      check("rst_rsp_data", mmio_rsp_data, 64'd0);
      check("rst_csr_mode", 64'(csr_mode), 64'd0);
      check("rst_pt_paddr", pt_paddr, 64'd0);
      check("rst_pt_valid", 64'(pt_paddr_valid), 64'd0);
      idle(2);
      reset_n = 1'b1;
      idle(4);
      rd(A_PT,   9'd28, 1'b1, 64'd0);
      rd(A_MODE, 9'd29, 1'b1, 64'd0);
      idle(5);

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
